// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg
//   Shared definitions for the ADC capture controller:
//   - ctrl_state_t : sequencer states
//   - sample_t     : packed {Q,I} sample at the default component width
//   - idx_width()  : width of the in-frame sample index for a given frame length
package adc_ctrl_pkg;

  localparam int DEF_TWID = 16;

  typedef logic signed [2*DEF_TWID-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } ctrl_state_t;

  // Index must reach FRAME_LEN-1; a one-bit floor keeps degenerate sizes legal.
  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/adc_ctrl_out_reg.sv
// adc_ctrl_out_reg
//   Single-entry AXI-Stream output register. Loads one sample when told to,
//   holds data/last stable while the consumer stalls, and reports whether a
//   new sample may be written this cycle.
// Ports
//   clk, rst            clock; synchronous active-low reset
//   load                write load_data/load_last into the register
//   load_data/last      sample and end-of-frame flag to write
//   free                register empty or being emptied this cycle
//   m_tdata/tvalid/tlast/tready   AXIS master side
module adc_ctrl_out_reg #(
  parameter int SWID = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SWID-1:0] load_data,
  input  logic            load_last,
  output logic            free,
  output logic [SWID-1:0] m_tdata,
  output logic            m_tvalid,
  output logic            m_tlast,
  input  logic            m_tready
);
  import adc_ctrl_pkg::*;

  logic [SWID-1:0] data_reg;
  logic            valid_reg;
  logic            last_reg;

  // A write is safe when nothing is held or the held sample leaves this cycle.
  assign free = ~valid_reg | m_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      last_reg  <= load_last;
      valid_reg <= 1'b1;
    end else if (m_tready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign m_tdata  = data_reg;
  assign m_tvalid = valid_reg;
  assign m_tlast  = last_reg;

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Sequencer between a free-running, non-stallable ADC stream and the PFB.
//   Enables the ADC, discards SETTLE startup samples, frames the stream into
//   FRAME_LEN-sample frames with tlast, counts frames and flags sample loss.
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   start, stop, num_frames  run control (num_frames==0: run until stop)
//   adc_en                   ADC enable, high in SETTLE and CAPTURE
//   s_tdata, s_tvalid        ADC sample stream (no back-pressure)
//   m_tdata/tvalid/tready/tlast   framed output stream
//   busy, done, overflow     status; done is a one-cycle end-of-run pulse
//   frame_cnt                frames fully accepted this run
module adc_capture_ctrl #(
  parameter int TWID      = 16,
  parameter int FRAME_LEN = 2048,
  parameter int SETTLE    = 4,
  parameter int NF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [NF_W-1:0]   num_frames,
  output logic              adc_en,
  input  logic [2*TWID-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic [2*TWID-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [NF_W-1:0]   frame_cnt
);
  import adc_ctrl_pkg::*;

  localparam int IDX_W = idx_width(FRAME_LEN);
  localparam int ST_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [ST_W-1:0]  ST_INIT  = ST_W'(SETTLE);

  // The SETTLE parameter shadows the package state of the same name, so the
  // state is always referenced with its package scope.
  ctrl_state_t state_reg, state_next;

  logic [NF_W-1:0]  nf_reg;
  logic [NF_W-1:0]  frame_cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [ST_W-1:0]  settle_reg;
  logic             stop_pend_reg;
  logic             overflow_reg;
  logic             adc_en_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             out_free;
  logic             in_capture;
  logic             accept;
  logic             drop;
  logic             at_last;
  logic             frame_end;
  logic [NF_W-1:0]  frames_after;
  logic             quota_hit;
  logic             stop_now;

  assign in_capture   = (state_reg == CAPTURE);
  assign accept       = in_capture & s_tvalid & out_free;
  // The ADC cannot wait: a valid sample with the output register still
  // occupied is lost and ends the run.
  assign drop         = in_capture & s_tvalid & ~out_free;
  assign at_last      = (idx_reg == IDX_LAST);
  assign frame_end    = accept & at_last;
  assign frames_after = frame_cnt_reg + NF_W'(1);
  assign quota_hit    = (nf_reg != '0) && (frames_after == nf_reg);
  // A stop arriving on the very cycle a frame closes still ends the run there.
  assign stop_now     = stop_pend_reg | stop;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start)
          state_next = (SETTLE > 0) ? adc_ctrl_pkg::SETTLE : CAPTURE;
      end
      adc_ctrl_pkg::SETTLE: begin
        if (stop)
          state_next = DRAIN;
        else if (s_tvalid && settle_reg == ST_W'(1))
          state_next = CAPTURE;
      end
      CAPTURE: begin
        if (drop)
          state_next = DRAIN;
        else if (frame_end && (quota_hit || stop_now))
          state_next = DRAIN;
      end
      DRAIN: begin
        if (out_free)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      nf_reg        <= '0;
      frame_cnt_reg <= '0;
      idx_reg       <= '0;
      settle_reg    <= '0;
      stop_pend_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      adc_en_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      // Status outputs are decoded from the next state so they line up with
      // the state register without a combinational path to the ports.
      adc_en_reg <= (state_next == adc_ctrl_pkg::SETTLE) || (state_next == CAPTURE);
      busy_reg   <= (state_next != IDLE);
      done_reg   <= (state_next == DONE);

      case (state_reg)
        IDLE: begin
          if (start) begin
            nf_reg        <= num_frames;
            overflow_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            idx_reg       <= '0;
            stop_pend_reg <= 1'b0;
            settle_reg    <= ST_INIT;
          end
        end
        adc_ctrl_pkg::SETTLE: begin
          if (s_tvalid && settle_reg != '0)
            settle_reg <= settle_reg - ST_W'(1);
          if (stop)
            stop_pend_reg <= 1'b1;
        end
        CAPTURE: begin
          if (stop)
            stop_pend_reg <= 1'b1;
          if (drop)
            overflow_reg <= 1'b1;
          if (accept) begin
            if (at_last) begin
              idx_reg       <= '0;
              frame_cnt_reg <= frames_after;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  adc_ctrl_out_reg #(
    .SWID(2*TWID)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (s_tdata),
    .load_last (at_last),
    .free      (out_free),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready)
  );

  assign adc_en    = adc_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign overflow  = overflow_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

  localparam int TWID      = 16;
  localparam int SWID      = 2*TWID;
  localparam int FRAME_LEN = 8;
  localparam int SETTLE    = 2;
  localparam int NF_W      = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [NF_W-1:0] num_frames = '0;
  logic            adc_en;
  logic [SWID-1:0] s_tdata;
  logic            s_tvalid;
  logic [SWID-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [NF_W-1:0] frame_cnt;

  adc_capture_ctrl #(
    .TWID(TWID), .FRAME_LEN(FRAME_LEN), .SETTLE(SETTLE), .NF_W(NF_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_frames(num_frames),
    .adc_en(adc_en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Source: a free-running cycle counter as {~n, n}; always valid, so it
  // also exercises the "ignored while disabled" rule.
  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign s_tdata  = {~cyc[15:0], cyc[15:0]};
  assign s_tvalid = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_sample(input int n);
    logic [15:0] v;
    v = 16'(n);
    return {~v, v};
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // A run starts in the cycle start is seen while no run is active and ends
  // on done. Within a run, output k carries the source sample taken
  // SETTLE+1+k cycles after the start cycle; every FRAME_LEN-th output is tlast.
  logic was_reset = 1'b0;
  always @(posedge clk) if (!rst) was_reset <= 1'b1;

  bit          m_active = 1'b0;
  int          base = 0;
  int          k = 0;
  int          en_cnt = 0;
  int          last_cnt = 0;
  int          last_hs_cyc = 0;
  int          runs_done = 0;
  int          s_out = 0, s_last = 0, s_en = 0, s_gap = 0;
  bit          prev_stall = 1'b0;
  logic [SWID-1:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (was_reset) begin
      chk("busy", 32'(busy), 32'(m_active));
      if (!m_active) begin
        chk("idle_adc_en", 32'(adc_en), 0);
        chk("idle_tvalid", 32'(m_tvalid), 0);
        chk("idle_done", 32'(done), 0);
      end
      if (prev_stall) begin
        chk("hold_tvalid", 32'(m_tvalid), 1);
        chk("hold_tdata", m_tdata, prev_data);
        chk("hold_tlast", 32'(m_tlast), 32'(prev_last));
      end
      if (m_active && adc_en) en_cnt++;
      if (m_active && m_tvalid && m_tready) begin
        chk("tdata", m_tdata, exp_sample(base + SETTLE + 1 + k));
        chk("tlast", 32'(m_tlast), 32'(((k + 1) % FRAME_LEN) == 0));
        if (m_tlast) last_cnt++;
        k++;
        last_hs_cyc = int'(cyc);
      end
      prev_stall = m_tvalid && !m_tready && rst;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (!rst) begin
        m_active = 1'b0;
      end else if (done) begin
        s_out  = k;
        s_last = last_cnt;
        s_en   = en_cnt;
        s_gap  = int'(cyc) - last_hs_cyc;
        m_active = 1'b0;
        runs_done++;
      end else if (!m_active && start) begin
        m_active = 1'b1;
        base = int'(cyc);
        k = 0;
        en_cnt = 0;
        last_cnt = 0;
        last_hs_cyc = int'(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input int nf);
    num_frames = NF_W'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int r0;
    r0 = runs_done;
    for (int i = 0; i < limit && runs_done == r0; i++) tick();
    chk({name, "_done_seen"}, 32'(runs_done != r0), 1);
  endtask

  task automatic wait_outputs(input string name, input int n);
    for (int i = 0; i < 200 && k < n; i++) tick();
    chk({name, "_reach"}, 32'(k >= n), 1);
  endtask

  task automatic check_run(input string name, input int e_out, input int e_last,
                           input int e_fc, input int e_ovf);
    chk({name, "_outputs"}, 32'(s_out), 32'(e_out));
    chk({name, "_tlasts"}, 32'(s_last), 32'(e_last));
    chk({name, "_en_cycles"}, 32'(s_en), 32'(SETTLE + e_out));
    chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'(e_fc));
    chk({name, "_overflow"}, 32'(overflow), 32'(e_ovf));
    chk({name, "_done_gap"}, 32'(s_gap), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    // Reset state.
    chk("rst_adc_en", 32'(adc_en), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_tdata", m_tdata, 0);
    tick();

    // 1: two frames, no stalls. Literal pins for the model.
    run_start(2);
    wait_done("t1", 200);
    check_run("t1", 16, 2, 2, 0);
    chk("t1_lit_outputs", 32'(s_out), 16);
    chk("t1_lit_en", 32'(s_en), 18);
    $display("t1: outputs=%0d tlast=%0d en=%0d frame_cnt=%0d", s_out, s_last, s_en, frame_cnt);
    tick();

    // 2: continuous, stop during frame 2 -> exactly two whole frames.
    run_start(0);
    wait_outputs("t2", 11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t2", 200);
    check_run("t2", 16, 2, 2, 0);
    $display("t2: outputs=%0d tlast=%0d frame_cnt=%0d overflow=%0d", s_out, s_last, frame_cnt, overflow);
    tick();

    // 3: one stall cycle mid-frame -> overflow, held sample still delivered.
    run_start(1);
    wait_outputs("t3", 4);
    m_tready = 1'b0;
    tick();
    m_tready = 1'b1;
    wait_done("t3", 200);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_tlasts", 32'(s_last), 0);
    chk("t3_short", 32'(s_out > 0 && s_out < FRAME_LEN), 1);
    chk("t3_en_cycles", 32'(s_en), 32'(SETTLE + s_out + 1));
    chk("t3_frame_cnt", 32'(frame_cnt), 0);
    chk("t3_done_gap", 32'(s_gap), 1);
    $display("t3: outputs=%0d overflow=%0d", s_out, overflow);
    tick();

    // 4: ready toggling every cycle -> overflow at the first stalled accept.
    run_start(2);
    r0 = runs_done;
    for (int i = 0; i < 200 && runs_done == r0; i++) begin
      m_tready = ~m_tready;
      tick();
    end
    m_tready = 1'b1;
    chk("t4_done_seen", 32'(runs_done != r0), 1);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_tlasts", 32'(s_last), 0);
    chk("t4_short", 32'(s_out < FRAME_LEN), 1);
    chk("t4_en_cycles", 32'(s_en), 32'(SETTLE + s_out + 1));
    $display("t4: outputs=%0d overflow=%0d", s_out, overflow);
    tick();
    run_start(2);
    chk("t4_ovf_cleared", 32'(overflow), 0);
    wait_done("t4b", 200);
    check_run("t4b", 16, 2, 2, 0);
    $display("t4b: outputs=%0d overflow=%0d", s_out, overflow);
    tick();

    // 5: reset mid-frame aborts without done.
    run_start(1);
    wait_outputs("t5", 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t5_adc_en", 32'(adc_en), 0);
    chk("t5_tvalid", 32'(m_tvalid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    r0 = runs_done;
    repeat (30) tick();
    chk("t5_no_done", 32'(runs_done), 32'(r0));
    run_start(2);
    wait_done("t5b", 200);
    check_run("t5b", 16, 2, 2, 0);
    $display("t5: after reset rerun outputs=%0d", s_out);
    tick();

    // 6: start held high -> one run per IDLE visit.
    r0 = runs_done;
    num_frames = NF_W'(1);
    start = 1'b1;
    wait_done("t6a", 200);
    check_run("t6a", 8, 1, 1, 0);
    repeat (3) tick();
    start = 1'b0;
    wait_done("t6b", 200);
    check_run("t6b", 8, 1, 1, 0);
    chk("t6_runs", 32'(runs_done - r0), 2);
    repeat (20) tick();
    chk("t6_no_extra_run", 32'(runs_done - r0), 2);
    chk("t6_idle_busy", 32'(busy), 0);
    $display("t6: runs=%0d", runs_done - r0);
    // stop alone in IDLE does nothing.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("t6_stop_idle_busy", 32'(busy), 0);
    // start and stop together: start wins, stop is dropped.
    num_frames = NF_W'(1);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    wait_done("t6c", 200);
    check_run("t6c", 8, 1, 1, 0);
    $display("t6c: start+stop outputs=%0d", s_out);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
